// File: rtl/jam_cost_loader.sv
// JAM front-end: cost table loader, JAM run control,
// result capture with ack handshake and watchdog.
module jam_cost_loader #(
  parameter int COST_W  = 7,
  parameter int ENTRIES = 64,
  parameter int TIMEOUT = 600000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COST_W-1:0] in_data,
  input  logic              in_last,
  input  logic [2:0]        W,
  input  logic [2:0]        J,
  output logic [COST_W-1:0] Cost,
  output logic              jam_rst,
  input  logic              Valid,
  input  logic [9:0]        MinCost,
  input  logic [3:0]        MatchCount,
  output logic              res_valid,
  input  logic              res_ack,
  output logic [9:0]        res_min_cost,
  output logic [3:0]        res_match_count,
  output logic              res_timeout,
  output logic              load_err
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  localparam logic [19:0] RUN_LAST = 20'(TIMEOUT - 1);
  localparam logic [5:0]  PTR_LAST = 6'(ENTRIES - 1);

  state_t            state;
  logic [5:0]        wr_ptr;
  logic [19:0]       run_cnt;
  logic [COST_W-1:0] mem [ENTRIES];
  logic              acc;

  assign in_ready = (state == LOAD);
  assign jam_rst  = (state != RUN);
  assign acc      = in_valid && in_ready;
  assign Cost     = mem[{W, J}];

  // Table write port; contents survive reset.
  always_ff @(posedge CLK) begin
    if (RST && acc) mem[wr_ptr] <= in_data;
  end

  // Control FSM with registered result and error outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      run_cnt         <= '0;
      res_valid       <= 1'b0;
      res_min_cost    <= '0;
      res_match_count <= '0;
      res_timeout     <= 1'b0;
      load_err        <= 1'b0;
    end else begin
      load_err <= 1'b0;
      unique case (state)
        IDLE: state <= LOAD;
        LOAD: begin
          if (acc) begin
            if (wr_ptr == PTR_LAST && in_last) begin
              state   <= RUN;
              run_cnt <= '0;
              wr_ptr  <= '0;
            end else if (wr_ptr == PTR_LAST || in_last) begin
              load_err <= 1'b1;
              wr_ptr   <= '0;
            end else begin
              wr_ptr <= wr_ptr + 6'd1;
            end
          end
        end
        RUN: begin
          run_cnt <= run_cnt + 20'd1;
          if (Valid) begin
            res_min_cost    <= MinCost;
            res_match_count <= MatchCount;
            res_timeout     <= 1'b0;
            res_valid       <= 1'b1;
            state           <= DONE;
          end else if (run_cnt == RUN_LAST) begin
            res_min_cost    <= 10'h3FF;
            res_match_count <= '0;
            res_timeout     <= 1'b1;
            res_valid       <= 1'b1;
            state           <= DONE;
          end
        end
        DONE: begin
          if (res_valid && res_ack) begin
            res_valid <= 1'b0;
            wr_ptr    <= '0;
            state     <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jam_cost_loader.sv
// Directed bench for jam_cost_loader with a result
// scoreboard checked by an independent monitor.
module tb_jam_cost_loader;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [6:0] in_data = '0;
  logic       in_last = 1'b0;
  logic [2:0] W = '0;
  logic [2:0] J = '0;
  logic [6:0] Cost;
  logic       jam_rst;
  logic       Valid = 1'b0;
  logic [9:0] MinCost = '0;
  logic [3:0] MatchCount = '0;
  logic       res_valid;
  logic       res_ack = 1'b0;
  logic [9:0] res_min_cost;
  logic [3:0] res_match_count;
  logic       res_timeout;
  logic       load_err;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [9:0] mc;
    logic [3:0] cnt;
    logic       to;
  } res_t;

  res_t q[$];

  jam_cost_loader #(
    .COST_W (7),
    .ENTRIES(64),
    .TIMEOUT(100)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_last        (in_last),
    .W              (W),
    .J              (J),
    .Cost           (Cost),
    .jam_rst        (jam_rst),
    .Valid          (Valid),
    .MinCost        (MinCost),
    .MatchCount     (MatchCount),
    .res_valid      (res_valid),
    .res_ack        (res_ack),
    .res_min_cost   (res_min_cost),
    .res_match_count(res_match_count),
    .res_timeout    (res_timeout),
    .load_err       (load_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // Result monitor: compares on each res_valid rise.
  logic rv_q = 1'b0;
  always @(negedge CLK) begin
    if (res_valid && !rv_q) begin
      if (q.size() == 0) begin
        chk("result_unexpected", 32'd1, 32'd0);
      end else begin
        res_t e;
        e = q.pop_front();
        chk("result_min_cost", 32'(res_min_cost), 32'(e.mc));
        chk("result_match", 32'(res_match_count), 32'(e.cnt));
        chk("result_timeout", 32'(res_timeout), 32'(e.to));
      end
    end
    rv_q <= res_valid;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [6:0] dat(input int mode,
                                     input int k);
    if (mode == 0) return 7'(k % 100);
    return 7'((k * 3) % 128);
  endfunction

  task automatic send_beat(input logic [6:0] d,
                           input logic last);
    int t = 0;
    while (!in_ready && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) chk("beat_wait", 32'd0, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
  endtask

  task automatic load(input int n, input int lastk,
                      input bit gap, input int mode);
    for (int k = 0; k < n; k++) begin
      if (gap && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        tick();
      end
      send_beat(dat(mode, k), k == lastk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_table(input int mode);
    for (int k = 0; k < 64; k++) begin
      W = 3'(k / 8);
      J = 3'(k % 8);
      #1;
      chk("table_entry", 32'(Cost), 32'(dat(mode, k)));
    end
    tick();
  endtask

  task automatic finish_run(input logic [9:0] mc,
                            input logic [3:0] cnt);
    Valid      = 1'b1;
    MinCost    = mc;
    MatchCount = cnt;
    q.push_back('{mc: mc, cnt: cnt, to: 1'b0});
    tick();
    Valid = 1'b0;
    chk("run_res_valid", 32'(res_valid), 32'd1);
    chk("run_jam_rst", 32'(jam_rst), 32'd1);
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    chk("ack_res_valid", 32'(res_valid), 32'd0);
    chk("ack_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1);
  end

  initial begin
    int n;
    // Scenario 1: reset and clean load.
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_jam_rst", 32'(jam_rst), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_min_cost", 32'(res_min_cost), 32'd0);
    chk("rst_match", 32'(res_match_count), 32'd0);
    chk("rst_timeout", 32'(res_timeout), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    RST = 1'b1;
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("load_in_ready", 32'(in_ready), 32'd1);
    load(64, 63, 1'b0, 0);
    chk("s1_jam_rst", 32'(jam_rst), 32'd0);
    chk("s1_in_ready", 32'(in_ready), 32'd0);
    W = 3'd3; J = 3'd5; #1;
    chk("cost_3_5", 32'(Cost), 32'd29);
    W = 3'd7; J = 3'd7; #1;
    chk("cost_7_7", 32'(Cost), 32'd63);
    W = 3'd5; J = 3'd3; #1;
    chk("cost_5_3", 32'(Cost), 32'd43);
    tick();

    // Scenario 4: capture and hold under no-ack.
    Valid = 1'b1; MinCost = 10'd267; MatchCount = 4'd2;
    q.push_back('{mc: 10'd267, cnt: 4'd2, to: 1'b0});
    tick();
    Valid = 1'b0; MinCost = 10'd1; MatchCount = 4'd9;
    chk("s4_res_valid", 32'(res_valid), 32'd1);
    chk("s4_jam_rst", 32'(jam_rst), 32'd1);
    repeat (5) begin
      tick();
      chk("s4_hold_valid", 32'(res_valid), 32'd1);
      chk("s4_hold_min", 32'(res_min_cost), 32'd267);
      chk("s4_hold_match", 32'(res_match_count), 32'd2);
      chk("s4_hold_to", 32'(res_timeout), 32'd0);
    end
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    chk("s4_ack_valid", 32'(res_valid), 32'd0);
    chk("s4_ack_ready", 32'(in_ready), 32'd1);

    // Valid outside RUN has no effect.
    Valid = 1'b1;
    tick();
    Valid = 1'b0;
    tick();
    chk("load_valid_ignored", 32'(res_valid), 32'd0);

    // Scenario 2: gapped load.
    load(64, 63, 1'b1, 0);
    chk("s2_jam_rst", 32'(jam_rst), 32'd0);
    check_table(0);
    finish_run(10'd5, 4'd8);

    // Scenario 3: early in_last, then clean load.
    load(11, 10, 1'b0, 0);
    chk("s3a_load_err", 32'(load_err), 32'd1);
    chk("s3a_in_ready", 32'(in_ready), 32'd1);
    chk("s3a_jam_rst", 32'(jam_rst), 32'd1);
    tick();
    chk("s3a_err_pulse", 32'(load_err), 32'd0);
    load(64, 63, 1'b0, 1);
    chk("s3a_run", 32'(jam_rst), 32'd0);
    check_table(1);
    finish_run(10'd9, 4'd1);

    // Scenario 3b: 64 beats without in_last.
    load(64, -1, 1'b0, 0);
    chk("s3b_load_err", 32'(load_err), 32'd1);
    chk("s3b_jam_rst", 32'(jam_rst), 32'd1);
    tick();
    chk("s3b_err_pulse", 32'(load_err), 32'd0);
    chk("s3b_no_run", 32'(jam_rst), 32'd1);
    chk("s3b_in_ready", 32'(in_ready), 32'd1);

    // Scenario 5: watchdog timeout.
    load(64, 63, 1'b0, 0);
    chk("s5_run", 32'(jam_rst), 32'd0);
    q.push_back('{mc: 10'd1023, cnt: 4'd0, to: 1'b1});
    n = 0;
    while (!res_valid && n < 300) begin
      tick();
      n++;
    end
    chk("s5_timeout_cycles", 32'(n), 32'd100);
    chk("s5_timeout_flag", 32'(res_timeout), 32'd1);
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;

    // Scenario 5b: Valid on the final watchdog cycle.
    load(64, 63, 1'b0, 0);
    repeat (99) tick();
    chk("s5b_still_run", 32'(jam_rst), 32'd0);
    Valid = 1'b1; MinCost = 10'd300; MatchCount = 4'd3;
    q.push_back('{mc: 10'd300, cnt: 4'd3, to: 1'b0});
    tick();
    Valid = 1'b0;
    chk("s5b_res_valid", 32'(res_valid), 32'd1);
    chk("s5b_timeout", 32'(res_timeout), 32'd0);
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;

    // Scenario 6: reset mid-load.
    load(31, -1, 1'b0, 0);
    RST = 1'b0;
    tick();
    chk("s6_rst_ready", 32'(in_ready), 32'd0);
    chk("s6_rst_jam", 32'(jam_rst), 32'd1);
    RST = 1'b1;
    tick();
    chk("s6_ready_back", 32'(in_ready), 32'd1);
    load(34, 33, 1'b0, 0);
    chk("s6_short_err", 32'(load_err), 32'd1);
    chk("s6_short_norun", 32'(jam_rst), 32'd1);
    load(64, 63, 1'b0, 0);
    chk("s6_full_run", 32'(jam_rst), 32'd0);
    check_table(0);

    // Reset mid-run aborts back to idle.
    RST = 1'b0;
    tick();
    chk("s6_run_rst_jam", 32'(jam_rst), 32'd1);
    chk("s6_run_rst_valid", 32'(res_valid), 32'd0);
    RST = 1'b1;
    repeat (2) tick();
    chk("s6_run_rst_load", 32'(in_ready), 32'd1);
    tick();
    chk("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/jam_cost_loader.md
Name: jam_cost_loader

Overview:
Upstream front-end for the JAM job-assignment solver.
- Accepts the 8x8 cost table as a 64-beat valid/ready stream and stores it.
- Serves Cost to JAM with zero latency from JAM's W/J lookup.
- Holds JAM in reset until the table is complete, captures JAM's MinCost/MatchCount on Valid, and presents the result on a ready/ack interface.
- Provides a watchdog timeout if JAM never asserts Valid.

Parameters:
- COST_W, 7, cost entry width.
- ENTRIES, 64, table depth (8 workers x 8 jobs, row-major index worker*8+job).
- TIMEOUT, 600000, maximum RUN cycles without Valid before a timeout result is forced.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  reset. One clock; reset is synchronous and active-low.
- in_valid  in  1  cost beat valid.
- in_ready  out  1  loader can accept a beat.
- in_data  in  7  cost value; beat k is stored at index k.
- in_last  in  1  marks the final (64th) beat.
- W  in  3  worker index from JAM.
- J  in  3  job index from JAM.
- Cost  out  7  table[{W,J}], combinational.
- jam_rst  out  1  active-high reset to JAM.
- Valid  in  1  JAM result valid.
- MinCost  in  10  JAM minimum cost.
- MatchCount  in  4  JAM match count.
- res_valid  out  1  result available.
- res_ack  in  1  consumer accepts result.
- res_min_cost  out  10  captured MinCost.
- res_match_count  out  4  captured MatchCount.
- res_timeout  out  1  result was forced by the watchdog.
- load_err  out  1  one-cycle pulse on a framing error.

Behaviour:
- States: IDLE, LOAD, RUN, DONE.
- Reset: any posedge with RST=0 sets:
  - state=IDLE, wr_ptr=0, run_cnt=0;
  - res_valid=0, res_min_cost=0, res_match_count=0, res_timeout=0, load_err=0.
  - Table contents are not cleared; Cost is undefined until the first complete load.
- Decoded outputs: in_ready = (state==LOAD); jam_rst = (state!=RUN). Both are decoded from the state register only.
- IDLE: goes to LOAD on the next edge, unconditionally.
- LOAD, handshake: a beat is accepted on a posedge with in_valid&&in_ready. On acceptance, table[wr_ptr]<=in_data and wr_ptr++. Beats without the handshake are ignored.
- LOAD, good completion: accepted beat with wr_ptr==63 and in_last=1 -> state=RUN, run_cnt=0.
- LOAD, framing error (either case below): load_err=1 for exactly the next cycle, wr_ptr=0, stay in LOAD. The partial data is discarded; overwriting on the next load is acceptable.
  - accepted beat with in_last=1 and wr_ptr<63;
  - accepted beat with wr_ptr==63 and in_last=0.
- Cost = table[W*8+J], combinational in every state. Same-cycle writes are not forwarded (JAM is held in reset during LOAD).
- RUN:
  - run_cnt increments every cycle.
  - If Valid=1: capture MinCost/MatchCount into res_* registers, res_timeout<=0, res_valid<=1, state<=DONE.
  - Else if run_cnt==TIMEOUT-1: res_min_cost<=10'h3FF, res_match_count<=0, res_timeout<=1, res_valid<=1, state<=DONE.
  - Valid and timeout in the same cycle: Valid wins.
  - Result latency: res_valid rises one cycle after Valid is sampled.
  - jam_rst returns to 1 in that same cycle.
  - run_cnt is 20 bits wide.
- DONE:
  - res_* outputs stay stable while res_valid=1 && res_ack=0.
  - On res_valid&&res_ack: res_valid<=0, wr_ptr<=0, state<=LOAD, ready for a new table.
- Valid is ignored outside RUN. res_ack is ignored when res_valid=0. in_valid is ignored outside LOAD (in_ready=0).
- Reset asserted in any state, including mid-LOAD or mid-RUN, aborts the operation. A new full 64-beat load is then required.

Test Plan:
1. Reset 3 cycles, then stream in_data=k mod 100 for k=0..63 (in_last on k=63) -> in_ready=1 from the 2nd cycle after reset; jam_rst falls the cycle after beat 63; W=3,J=5 gives Cost=29; W=7,J=7 gives Cost=63.
2. Same load with in_valid randomly deasserted ~50% -> only handshaken beats are stored; table identical to scenario 1; the RUN entry cycle shifts accordingly.
3. in_last on beat 10 -> load_err high exactly 1 cycle, state stays LOAD, wr_ptr=0; a following clean 64-beat load enters RUN. A separate case with 64 beats and no in_last -> load_err pulses and RUN is not entered.
4. In RUN, drive Valid=1 with MinCost=267, MatchCount=2 for one cycle -> next cycle res_valid=1, res_min_cost=267, res_match_count=2, res_timeout=0, jam_rst=1. Hold res_ack=0 for 5 cycles -> outputs stable. res_ack=1 -> res_valid=0, in_ready=1.
5. TIMEOUT=100, no Valid -> res_valid exactly 100 cycles after RUN entry, res_timeout=1, res_min_cost=1023, res_match_count=0. Valid on cycle 99 instead -> normal capture with res_timeout=0.
6. RST=0 after beat 30 -> in_ready=0, jam_rst=1; after release, 34 more beats do not enter RUN, while a full 64-beat load does.
